vec_length_module: RTL

VEC_LENGTH_MODULE -- requirements
Module: vec_length_module

---
 rtl/vec_length_module.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vec_length_module.sv
// vec_length_module: Euclidean length of a signed 3-vector.
//   out = min(floor(sqrt(x0^2 + x1^2 + x2^2)), 32'h7FFFFFFF)
// Sits between a first-word-fall-through input FIFO and an output FIFO. One vector at a time:
// pop, square and sum (1 cycle), bit-serial restoring sqrt (32 cycles), push. The result
// keeps the Q format of the inputs.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   x[2:0]     signed 32-bit components, valid while in_empty = 0
//   in_empty   upstream FIFO empty
//   in_rd_en   upstream pop strobe (combinational, IDLE only)
//   out        registered, saturated vector length
//   out_full   downstream FIFO full
//   out_wr_en  downstream push strobe (combinational, WRITE only)
module vec_length_module (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [31:0] x [2:0],
  input  logic               in_empty,
  output logic               in_rd_en,
  output logic signed [31:0] out,
  input  logic               out_full,
  output logic               out_wr_en
);

  typedef enum logic [1:0] {StIdle, StSquare, StRoot, StWrite} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] x_q [2:0];
  logic [63:0]        rad_q, rad_d;    // radicand, consumed two bits per iteration from the top
  logic [31:0]        root_q, root_d;
  logic [34:0]        rem_q, rem_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [31:0] out_q, out_d;
  logic               capture;

  // Exact squares; the sum cannot overflow 64 bits (max 3 * 2^62).
  logic signed [63:0] x_ext [2:0];
  logic [63:0]        sq [2:0];
  logic [63:0]        sum_sq;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      x_ext[i] = {{32{x_q[i][31]}}, x_q[i]};
      sq[i]    = x_ext[i] * x_ext[i];
    end
    sum_sq = sq[0] + sq[1] + sq[2];
  end

  // One restoring sqrt iteration. The remainder never exceeds 2*root, so 33 bits carry it
  // between iterations; the shifted value and trial need 35.
  logic [34:0] rem_shift, trial, rem_new;
  logic        take;
  logic [31:0] root_new;
  logic        unused_rem_msb;

  always_comb begin
    rem_shift = {rem_q[32:0], rad_q[63:62]};
    trial     = {1'b0, root_q, 2'b01};
    take      = (rem_shift >= trial);
    rem_new   = take ? (rem_shift - trial) : rem_shift;
    root_new  = {root_q[30:0], take};
  end

  assign unused_rem_msb = ^rem_q[34:33];

  always_comb begin
    state_d   = state_q;
    rad_d     = rad_q;
    root_d    = root_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          capture  = 1'b1;
          state_d  = StSquare;
        end
      end
      StSquare: begin
        rad_d   = sum_sq;
        root_d  = '0;
        rem_d   = '0;
        cnt_d   = 5'd31;
        state_d = StRoot;
      end
      StRoot: begin
        rad_d  = {rad_q[61:0], 2'b00};
        root_d = root_new;
        rem_d  = rem_new;
        if (cnt_q == 5'd0) begin
          // Roots of 2^31 and above do not fit the signed output.
          out_d   = root_new[31] ? 32'sh7FFFFFFF : $signed(root_new);
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StWrite: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Strobes stay low for the whole reset pulse, not just after the state register clears.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < 3; i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      if (capture) begin
        for (int i = 0; i < 3; i++) x_q[i] <= x[i];
      end
    end
  end

  assign out = out_q;

endmodule
